// File: rtl/clk_rst_gen.sv
// -----------------------------------------------------------------------------
// clk_rst_gen
//
// Takes one fast clock and produces NCH divided clocks, each with a matching
// one-cycle clock-enable strobe. It also produces a design reset that follows
// a filtered PLL/DCM lock indication.
//
// Each channel's divide ratio can be changed at run time. A new ratio first
// goes into a pending register and takes effect only when the channel wraps.
// The period in progress therefore always finishes at the old ratio, so
// clk_div never emits a runt pulse.
//
// Ports
//   clk      in   fast clock (PLL/DCM CLKFX domain)
//   rst_     in   synchronous active-low reset
//   lock     in   PLL/DCM locked; asynchronous source, sampled once by the
//                 lock filter register
//   div      in   NCH*DW requested ratios; channel i uses div[i*DW +: DW]
//   div_ld   in   one-cycle pulse that copies div into every pending register
//   clk_div  out  divided clock per channel, high for floor(N/2) cycles
//   ce       out  per-channel strobe, high in the last fast cycle of a period
//   rst      out  active-high design reset
//   lock_ok  out  lock seen high for LOCK_FILT consecutive cycles
// -----------------------------------------------------------------------------
module clk_rst_gen #(
    parameter int NCH       = 2,
    parameter int DW        = 8,
    parameter int DIV_DEF   = 8,
    parameter int RST_W     = 7,
    parameter int LOCK_FILT = 4
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                lock,
    input  logic [NCH*DW-1:0]   div,
    input  logic                div_ld,
    output logic [NCH-1:0]      clk_div,
    output logic [NCH-1:0]      ce,
    output logic                rst,
    output logic                lock_ok
);

    localparam int             FW       = $clog2(LOCK_FILT + 1);
    localparam logic [DW-1:0]  DIV_INIT = DW'(DIV_DEF);
    localparam logic [DW-1:0]  DIV_MIN  = DW'(2);
    localparam logic [FW-1:0]  FILT_MAX = FW'(LOCK_FILT);

    // Goes high at the first edge after rst_ rises. The cycle that follows
    // that edge is count value 0 for every channel.
    logic run_reg;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Divider channels
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DW-1:0] pend_reg;
            logic [DW-1:0] act_reg,  act_next;
            logic [DW-1:0] cnt_reg,  cnt_next;
            logic [DW-1:0] neff_cur, neff_next;
            logic          wrap;
            logic          clk_div_reg, ce_reg;

            // Ratios 0 and 1 cannot give a valid clock, so they are run as 2.
            assign neff_cur = (act_reg < DIV_MIN) ? DIV_MIN : act_reg;
            assign wrap     = run_reg && (cnt_reg == neff_cur - DW'(1));

            always_comb begin
                act_next = act_reg;
                cnt_next = cnt_reg + DW'(1);
                if (!run_reg) begin
                    cnt_next = '0;
                end else if (wrap) begin
                    // The pending value is sampled before any div_ld in this
                    // same cycle updates it, so a simultaneous load waits
                    // for the next wrap.
                    act_next = pend_reg;
                    cnt_next = '0;
                end
                neff_next = (act_next < DIV_MIN) ? DIV_MIN : act_next;
            end

            always_ff @(posedge clk) begin
                if (!rst_) begin
                    pend_reg    <= DIV_INIT;
                    act_reg     <= DIV_INIT;
                    cnt_reg     <= '0;
                    clk_div_reg <= 1'b0;
                    ce_reg      <= 1'b0;
                end else begin
                    if (div_ld) begin
                        pend_reg <= div[gi*DW +: DW];
                    end
                    act_reg     <= act_next;
                    cnt_reg     <= cnt_next;
                    // Outputs are decoded from the next count, so the
                    // registered outputs line up with the count they describe.
                    clk_div_reg <= (cnt_next < (neff_next >> 1));
                    ce_reg      <= (cnt_next == neff_next - DW'(1));
                end
            end

            assign clk_div[gi] = clk_div_reg;
            assign ce[gi]      = ce_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Lock filter: saturating run-length counter of consecutive high samples
    // -------------------------------------------------------------------------
    logic [FW-1:0] filt_reg, filt_next;
    logic          lock_ok_reg;

    always_comb begin
        filt_next = '0;
        if (lock) begin
            filt_next = (filt_reg == FILT_MAX) ? filt_reg : filt_reg + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            filt_reg    <= '0;
            lock_ok_reg <= 1'b0;
        end else begin
            filt_reg    <= filt_next;
            lock_ok_reg <= (filt_next == FILT_MAX);
        end
    end

    assign lock_ok = lock_ok_reg;

    // -------------------------------------------------------------------------
    // Reset sequencer: counts channel-0 periods while lock is trusted
    // -------------------------------------------------------------------------
    logic [RST_W-1:0] rcnt_reg, rcnt_next;
    logic             rst_reg;

    always_comb begin
        rcnt_next = rcnt_reg;
        if (!lock_ok_reg) begin
            rcnt_next = '0;
        end else if (ce[0] && (rcnt_reg != '1)) begin
            rcnt_next = rcnt_reg + RST_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            rcnt_reg <= '0;
            rst_reg  <= 1'b1;
        end else begin
            rcnt_reg <= rcnt_next;
            rst_reg  <= (rcnt_next != '1);
        end
    end

    assign rst = rst_reg;

endmodule

// File: doc/clk_rst_gen.md
Name: clk_rst_gen

Overview:
- Parametrised successor to the single-output clock divider/reset generator in the test harness.
- Derives NCH independently divided clocks and clock-enable strobes from one fast clock.
- Each channel's divide ratio is programmable at run time and changes without glitches.
- Lock input is glitch-filtered; the active-high design reset is held until lock is stable and a programmable number of channel-0 periods have elapsed.

Parameters:
NCH, 2, number of divider channels
DW, 8, divide-ratio width per channel
DIV_DEF, 8, divide ratio of every channel after reset
RST_W, 7, reset-stretch counter width; release after 2^RST_W-1 channel-0 ticks
LOCK_FILT, 4, consecutive high lock samples required before lock is trusted

Ports:
clk  in  1  fast clock (DCM/PLL CLKFX domain)
rst_  in  1  synchronous active-low reset
lock  in  1  DCM/PLL locked indication, asynchronous source, single-register sampled
div  in  NCH*DW  requested divide ratio N; channel i uses bits [i*DW +: DW]
div_ld  in  1  one-cycle pulse capturing div into pending registers
clk_div  out  NCH  divided clock per channel
ce  out  NCH  one-cycle strobe per channel, high in the last fast cycle of each divided period
rst  out  1  active-high design reset
lock_ok  out  1  filtered lock status

Behaviour:
- Reset (rst_=0 at a clk edge):
  - Channel counters c=0.
  - Active and pending N = DIV_DEF.
  - Filter counter = 0, lock_ok = 0, reset counter rcnt = 0.
  - Outputs forced: clk_div=0, ce=0, rst=1, lock_ok=0.
- Effective ratio: Neff = max(N,2). N of 0 or 1 is treated as 2.
- Channel counter:
  - c counts 0..Neff-1, wraps to 0.
  - In a cycle with count value c: clk_div = (c < Neff>>1), ce = (c == Neff-1).
  - Both outputs are registered; the implementation uses lookahead so the relation holds exactly with no extra lag.
  - Duty: high floor(Neff/2) cycles, low ceil(Neff/2) cycles.
  - Counting starts in the first cycle after rst_ rises; that cycle has c=0.
- Ratio change:
  - div_ld copies div into pending for all channels.
  - Each channel loads pending into active only on its wrap (cycle where ce=1). The new period starts at c=0.
  - The current period always completes at the old ratio; clk_div never produces a runt pulse.
  - A second div_ld before the wrap overwrites pending; the last value wins.
  - div_ld in the same cycle as a wrap: the wrap uses the old pending value; the new value applies at the next wrap.
- Lock filter:
  - Each cycle lock=1 increments the filter counter, saturating at LOCK_FILT; lock_ok = (filter == LOCK_FILT).
  - Any cycle with lock=0 clears the filter counter and lock_ok on the following edge.
- Reset sequencer:
  - Dividers free-run regardless of lock.
  - When lock_ok=0, rcnt is cleared.
  - Otherwise rcnt increments on each ce[0] cycle until it reaches all-ones, then holds.
  - rst = (rcnt != all-ones), registered, so rst falls in the cycle after the final increment.
  - Loss of lock after release re-asserts rst one cycle after lock_ok falls.
  - rst never falls while lock_ok=0.
- rst_ low mid-operation: all state returns to reset values at that edge, including pending ratios (back to DIV_DEF). A div_ld in the same cycle is ignored.

Test Plan:
1. Defaults (NCH=2, N=8, RST_W=7, LOCK_FILT=4), lock=1 from first post-reset cycle (cycle 0):
   - lock_ok=1 from cycle 4.
   - ce[0] at cycles 7, 15, ...
   - rst=1 through cycle 1015, 0 from cycle 1016.
   - clk_div[0] high cycles 0-3, low 4-7.
2. After release, lock=0 for one cycle at cycle 2000, then 1:
   - lock_ok=0 at 2001, rst=1 from 2002.
   - lock_ok=1 again 4 cycles after lock returns.
   - rst falls again after 127 further ce[0] pulses.
   - clk_div continues undisturbed throughout.
3. div[1] set to 5 via div_ld:
   - After the current period, channel 1 clk_div is high 2 / low 3, ce[1] every 5 cycles.
   - Channel 0 is unaffected.
4. div_ld with N=4 at c=3 of an N=8 period:
   - Period completes 8 cycles, then 4-cycle periods with no runt.
   - Two div_ld pulses (6 then 3) before the wrap: period 3 is used.
5. div=0 and div=1 loaded:
   - Channel behaves as N=2: clk_div toggles every cycle, ce every 2nd cycle.
6. rst_=0 for one cycle mid-operation with a pending ratio:
   - All outputs return to reset values, ratio reverts to 8.
   - Full release sequence restarts as in scenario 1.
